edge_detect_debounce: RTL
=========================

Name: edge_detect_debounce

Overview:
- Multi-channel, mode-selectable edge detector for asynchronous or noisy inputs, e.g. buttons and external triggers feeding the waveform generator control path.
- Each channel passes through:
  - a synchroniser chain;
  - a programmable debounce filter;
  - per-channel rise/fall/both edge selection, producing a one-cycle pulse and a sticky flag cleared by software.
- Generalises the single-mode rising-edge detector to N channels, four modes, filtering and event latching.

Parameters:
- WIDTH, 4, number of independent channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per channel (0..4); 0 means the input is already synchronous and the chain is bypassed.
- DEBOUNCE_W, 8, width of the debounce threshold and counter.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset; asynchronous and active-low.
- i_detect_in  in  WIDTH  raw channel inputs.
- i_mode  in  2*WIDTH  per-channel mode, channel k at bits [2k+1:2k]: 00 off, 01 rise, 10 fall, 11 both.
- i_db_thr  in  DEBOUNCE_W  debounce threshold, shared by all channels; 0 means no filtering.
- i_clr  in  WIDTH  per-channel sticky clear, level-sensitive.
- o_level  out  WIDTH  debounced, synchronised level.
- o_pulse  out  WIDTH  one-cycle edge pulse (mode-qualified).
- o_sticky  out  WIDTH  latched edge flags.
- o_any  out  1  OR of o_sticky (combinational).

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - Cleared: all sync flops, stable levels, counters, o_level, o_pulse and o_sticky.
  - o_any is 0.
- Sync: raw[k] is the output of the SYNC_STAGES-deep chain. With SYNC_STAGES=0, raw = i_detect_in.
- Debounce, per channel, on each clock edge:
  - If raw == stable: cnt <= 0.
  - Else if cnt >= i_db_thr: stable <= raw, cnt <= 0, and a change event fires this edge.
  - Else: cnt <= cnt+1; the counter saturates at all-ones.
- Consequences of the debounce rule:
  - A new level must persist for i_db_thr+1 consecutive sampled cycles.
  - Any shorter glitch resets cnt and produces no event.
- Latency: an input step sampled at edge 0 appears on o_level and o_pulse after SYNC_STAGES + i_db_thr + 1 edges.
- Pulse: o_pulse[k] is registered high for exactly one cycle, on the same edge that o_level[k] changes, when:
  - the change is 0->1 and mode is rise or both; or
  - the change is 1->0 and mode is fall or both.
  - Mode off never pulses.
- Level tracking (o_level) ignores mode.
- Sticky: o_sticky[k] is set on the edge o_pulse[k] rises and cleared while i_clr[k]=1. If set and clear occur together, set wins, so no event is lost.
- Mode changes take effect at the next change event. A change event that coincides with a mode write uses the mode sampled on that same edge.
- Threshold change mid-count: the comparison uses the current i_db_thr. If cnt already meets or exceeds a newly lowered threshold, the update occurs on the next edge.
- Reset release with an input held high: the stable level starts at 0, so the channel produces a rising event after the normal latency.
- Channels are fully independent; simultaneous events on several channels are all reported.

Decomposition:
- Package edge_pkg:
  - typedef enum logic [1:0] edge_mode_e {EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH};
  - localparam MODE_W = 2.
- Sub-module edge_chan holds one channel's sync chain, debounce counter, pulse and sticky logic.
- The top module generates WIDTH instances and the o_any reduction.

Test Plan:
- Reset/latency: SYNC_STAGES=2, thr=0, mode ch0=rise, ch0 steps 0->1 at edge 10 -> o_level[0] and o_pulse[0] high at edge 13, pulse one cycle wide, o_sticky[0]=1 and o_any=1 from edge 13.
- Debounce filtering: thr=4, 3-cycle high glitch on ch1 -> no o_level or o_pulse change. Then a 5-cycle-or-longer high -> o_level[1] rises 2+5 edges after the step.
- Modes: ch0..3 set to off/rise/fall/both, each given one 0->1->0 pulse lasting 20 cycles -> pulse counts 0, 1, 1, 2; o_level toggles on all four channels.
- Sticky priority: ch2 event edge coincides with i_clr[2]=1 -> o_sticky[2]=1. Next cycle with i_clr still 1 -> 0. i_clr pulse with no event -> stays 0.
- Async reset mid-count: thr=200, assert i_rst_n=0 mid-debounce without waiting for a clock edge -> all outputs 0 immediately. After release with input held high -> rising pulse after 2+201 edges.
- Concurrency: all 4 channels, mode both, step simultaneously -> o_pulse=4'hF for exactly one cycle.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared types for the multi-channel edge detector: per-channel mode encoding
// and a helper that decides whether a level change is reported.
package edge_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    function automatic logic edge_qualifies(input edge_mode_e mode, input logic new_level);
        logic hit;
        hit = 1'b0;
        unique case (mode)
            EDGE_OFF:  hit = 1'b0;
            EDGE_RISE: hit = new_level;
            EDGE_FALL: hit = ~new_level;
            EDGE_BOTH: hit = 1'b1;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One detector channel: synchroniser chain, debounce filter, mode-qualified
// edge pulse and a software-cleared sticky flag.
module edge_chan
    import edge_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE_W  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_detect_in,
    input  edge_mode_e            i_mode,
    input  logic [DEBOUNCE_W-1:0] i_db_thr,
    input  logic                  i_clr,
    output logic                  o_level,
    output logic                  o_pulse,
    output logic                  o_sticky
);

    logic                  raw;
    logic                  stable_q;
    logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
    logic                  pulse_q, pulse_d;
    logic                  sticky_q, sticky_d;
    logic                  change;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign raw = i_detect_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= i_detect_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign raw = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        change   = (raw != stable_q) && (cnt_q >= i_db_thr);
        cnt_d    = cnt_q;
        if ((raw == stable_q) || change) begin
            cnt_d = '0;
        end else if (cnt_q != {DEBOUNCE_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
        pulse_d  = change && edge_qualifies(i_mode, raw);
        // A fresh event outranks a simultaneous clear so nothing is lost.
        sticky_d = pulse_d | (sticky_q & ~i_clr);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            if (change) begin
                stable_q <= raw;
            end
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            sticky_q <= sticky_d;
        end
    end

    assign o_level  = stable_q;
    assign o_pulse  = pulse_q;
    assign o_sticky = sticky_q;

endmodule

// File: rtl/edge_detect_debounce.sv
// Multi-channel debounced edge detector: WIDTH independent channels plus an
// aggregate "any flag set" output.
module edge_detect_debounce
    import edge_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE_W  = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [WIDTH-1:0]        i_detect_in,
    input  logic [MODE_W*WIDTH-1:0] i_mode,
    input  logic [DEBOUNCE_W-1:0]   i_db_thr,
    input  logic [WIDTH-1:0]        i_clr,
    output logic [WIDTH-1:0]        o_level,
    output logic [WIDTH-1:0]        o_pulse,
    output logic [WIDTH-1:0]        o_sticky,
    output logic                    o_any
);

    for (genvar k = 0; k < WIDTH; k++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_W  (DEBOUNCE_W)
        ) u_chan (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .i_detect_in (i_detect_in[k]),
            .i_mode      (edge_mode_e'(i_mode[MODE_W*k +: MODE_W])),
            .i_db_thr    (i_db_thr),
            .i_clr       (i_clr[k]),
            .o_level     (o_level[k]),
            .o_pulse     (o_pulse[k]),
            .o_sticky    (o_sticky[k])
        );
    end

    assign o_any = |o_sticky;

endmodule
